// File: rtl/serial_adder_if.sv
//==============================================================================
// Module      : serial_adder_if
// Description : Request/result bundle for the bit-serial adder/subtractor.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, a, b,
        input  sum, carry_out, overflow, busy, done
    );

    modport slave (
        input  start, sub, a, b,
        output sum, carry_out, overflow, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
//==============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtractor, one full-adder slice, LSB first.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int            CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] C_LAST  = CW'(WIDTH - 1);
    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_SHIFT = 2'd1;
    localparam logic [1:0]    S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last = (r_cnt == C_LAST);

    // DONE also accepts start so back-to-back runs sustain one op per WIDTH+1 cycles.
    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = bus.start ? S_SHIFT : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_shift <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_c;
            r_shift <= {w_s, r_shift[WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= {w_s, r_shift[WIDTH-1:1]};
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.carry_out = r_cout;
    assign bus.overflow  = r_ovf;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//==============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder with directed vectors.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_adder;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(WIDTH)) ifc ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int               tests    = 0;
    int               fails    = 0;
    int               done_cnt = 0;
    logic [WIDTH+1:0] sb_q[$];
    logic [WIDTH+1:0] m_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ifc.done === 1'b1) begin
            done_cnt++;
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got sum=0x%0h c=%0b v=%0b expected no result",
                         ifc.sum, ifc.carry_out, ifc.overflow);
            end else begin
                m_exp = sb_q.pop_front();
                if ({ifc.sum, ifc.carry_out, ifc.overflow} !== m_exp) begin
                    fails++;
                    $display("FAIL result: got sum=0x%0h c=%0b v=%0b expected sum=0x%0h c=%0b v=%0b",
                             ifc.sum, ifc.carry_out, ifc.overflow,
                             m_exp[WIDTH+1:2], m_exp[1], m_exp[0]);
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    // One operation with latency and busy checks; inputs are scrambled after acceptance.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tsub, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo);
        int n  = 0;
        bit ok = 1'b1;
        @(negedge clk);
        ifc.a     = ta;
        ifc.b     = tb;
        ifc.sub   = tsub;
        ifc.start = 1'b1;
        sb_q.push_back({es, ec, eo});
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.a     = ~ta;
        ifc.b     = ~tb;
        ifc.sub   = ~tsub;
        while (ifc.done !== 1'b1 && n < 20) begin
            if (ifc.busy !== 1'b1) ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, WIDTH);
        check("busy_during", {31'b0, ok}, 1);
        @(posedge clk);
        #1;
        check("busy_after", {31'b0, ifc.busy}, 0);
        check("done_single", {31'b0, ifc.done}, 0);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int n_done;
        int last_k;
        bit period_ok;
        bit stable_ok;

        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.sub   = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum",  {24'b0, ifc.sum}, 0);
        check("rst_cout", {31'b0, ifc.carry_out}, 0);
        check("rst_ovf",  {31'b0, ifc.overflow}, 0);
        check("rst_busy", {31'b0, ifc.busy}, 0);
        check("rst_done", {31'b0, ifc.done}, 0);
        rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start pulse mid-operation with new operands must be ignored
        d0 = done_cnt;
        @(negedge clk);
        ifc.a = 8'h01; ifc.b = 8'h01; ifc.sub = 1'b0; ifc.start = 1'b1;
        sb_q.push_back({8'h02, 1'b0, 1'b0});
        @(posedge clk);
        #1 ifc.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ifc.start = 1'b1; ifc.a = 8'hFF; ifc.b = 8'hFF;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        wait_drain();
        repeat (12) @(posedge clk);
        check("interf_done_count", done_cnt - d0, 1);

        // reset mid-operation aborts without a done pulse
        d0 = done_cnt;
        @(negedge clk);
        ifc.a = 8'h5A; ifc.b = 8'h33; ifc.sub = 1'b0; ifc.start = 1'b1;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, ifc.busy}, 0);
        check("abort_sum",  {24'b0, ifc.sum}, 0);
        check("abort_cout", {31'b0, ifc.carry_out}, 0);
        check("abort_ovf",  {31'b0, ifc.overflow}, 0);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        // start held high for 30 edges: accepted at k = 0, 9, 18, 27
        n_done    = 0;
        last_k    = -1;
        period_ok = 1'b1;
        stable_ok = 1'b1;
        @(negedge clk);
        ifc.a = 8'h10; ifc.b = 8'h20; ifc.sub = 1'b0; ifc.start = 1'b1;
        repeat (4) sb_q.push_back({8'h30, 1'b0, 1'b0});
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (ifc.done === 1'b1) begin
                if (last_k >= 0 && (k - last_k) != WIDTH + 1) period_ok = 1'b0;
                last_k = k;
                n_done++;
            end
            if (n_done > 0 && ifc.sum !== 8'h30) stable_ok = 1'b0;
            if (k == 29) ifc.start = 1'b0;
        end
        check("b2b_count",  n_done, 4);
        check("b2b_period", {31'b0, period_ok}, 1);
        check("b2b_stable", {31'b0, stable_ok}, 1);
        check("b2b_first",  last_k - 3 * (WIDTH + 1), WIDTH);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
